// File: rtl/reciprocal_seq.sv
// Sequential reciprocal generator: C = floor(2^PRECISION / B) via a
// one-bit-per-cycle restoring divider with valid/ready on both sides.
module reciprocal_seq #(
    parameter int ARG_BIT_WIDTH = 32,
    parameter int PRECISION     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ARG_BIT_WIDTH-1:0] B,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PRECISION-1:0]     C,
    output logic                     DZ
);

    localparam int CNT_W = $clog2(PRECISION + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(PRECISION);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [ARG_BIT_WIDTH-1:0] divisor;
    logic [ARG_BIT_WIDTH:0]   rem;
    logic [ARG_BIT_WIDTH:0]   rem_shift;
    logic [ARG_BIT_WIDTH:0]   rem_next;
    logic [PRECISION:0]       quo;
    logic [PRECISION:0]       quo_next;
    logic [CNT_W-1:0]         cnt;
    logic                     dividend_bit;
    logic                     q_bit;
    logic                     last_iter;
    logic                     accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = (B == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Dividend is a single 1 followed by PRECISION zeros, so only the first
    // iteration shifts in a 1. The remainder's top bit is always 0 before the
    // shift because the stored remainder is strictly less than the divisor.
    always_comb begin
        dividend_bit = (cnt == '0);
        rem_shift    = (rem << 1) | (ARG_BIT_WIDTH + 1)'(dividend_bit);
        q_bit        = 1'b0;
        rem_next     = rem_shift;
        if (rem_shift >= {1'b0, divisor}) begin
            rem_next = rem_shift - {1'b0, divisor};
            q_bit    = 1'b1;
        end
        quo_next  = (quo << 1) | (PRECISION + 1)'(q_bit);
        last_iter = (cnt == LAST_ITER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            C       <= '0;
            DZ      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        divisor <= B;
                        rem     <= '0;
                        quo     <= '0;
                        cnt     <= '0;
                        if (B == '0) begin
                            C  <= '1;
                            DZ <= 1'b1;
                        end else begin
                            DZ <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + CNT_W'(1);
                    // Quotient MSB only appears for B==1; saturate instead of wrapping to 0.
                    if (last_iter) begin
                        C  <= quo_next[PRECISION] ? {PRECISION{1'b1}} : quo_next[PRECISION-1:0];
                        DZ <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reciprocal_seq.sv
// Randomized self-checking bench for reciprocal_seq against an arithmetic
// reference model of floor(2^64 / B) with saturation and divide-by-zero.
module tb_reciprocal_seq;

    localparam int W = 32;
    localparam int P = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] c;
    logic         dz;

    int n_checks = 0;
    int n_fail   = 0;

    reciprocal_seq #(
        .ARG_BIT_WIDTH(W),
        .PRECISION    (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .B        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .C        (c),
        .DZ       (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [P-1:0] got, input logic [P-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [P-1:0] model_c(input logic [W-1:0] d);
        logic [P:0] num;
        logic [P:0] q;
        if (d == 0) return {P{1'b1}};
        num = {1'b1, {P{1'b0}}};
        q   = num / {{(P + 1 - W){1'b0}}, d};
        if (q > {1'b0, {P{1'b1}}}) return {P{1'b1}};
        return q[P-1:0];
    endfunction

    function automatic int model_lat(input logic [W-1:0] d);
        return (d == 0) ? 0 : P + 1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] d);
        int g = 0;
        while (!in_ready && g < 200) begin
            tick();
            g++;
        end
        check("in_ready_before_issue", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        b        = d;
        tick();
        in_valid = 1'b0;
        b        = $urandom;
    endtask

    // Called right after the accept edge; measures edges until out_valid.
    task automatic collect(input logic [W-1:0] d, input int stall, input string tag);
        int           lat = 0;
        logic [P-1:0] exp_c;
        exp_c = model_c(d);
        while (!out_valid && lat < P + 10) begin
            check({tag, "_busy_in_ready"}, 64'(in_ready), 64'(0));
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(model_lat(d)));
        check({tag, "_c"}, c, exp_c);
        check({tag, "_dz"}, 64'(dz), 64'(d == 0));
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall_valid"}, 64'(out_valid), 64'(1));
            check({tag, "_stall_c"}, c, exp_c);
            check({tag, "_stall_in_ready"}, 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_post_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        int           lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        b         = '0;
        repeat (3) tick();
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_c", c, 64'(0));
        check("reset_dz", 64'(dz), 64'(0));
        rst = 1'b0;
        tick();

        // Leave a nonzero C behind so the mid-op reset visibly clears it.
        issue(32'd7);
        collect(32'd7, 0, "pre7");

        issue(32'd3);
        repeat (20) tick();
        check("midop_out_valid", 64'(out_valid), 64'(0));
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_c", c, 64'(0));
        check("midrst_dz", 64'(dz), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        tick();
        tick();
        rst = 1'b0;
        tick();
        issue(32'd2);
        check("b2_model", model_c(32'd2), 64'h8000_0000_0000_0000);
        collect(32'd2, 0, "b2");

        issue(32'd3);
        collect(32'd3, 0, "b3");
        issue(32'hFFFF_FFFF);
        collect(32'hFFFF_FFFF, 0, "bmax");
        issue(32'd1);
        collect(32'd1, 0, "b1");
        issue(32'd0);
        collect(32'd0, 0, "b0");
        issue(32'd7);
        collect(32'd7, 10, "b7_bp");

        // Busy input: B=9 offered on every cycle while B=5 is in flight.
        in_valid = 1'b1;
        b        = 32'd5;
        tick();
        b   = 32'd9;
        lat = 0;
        while (!out_valid && lat < P + 10) begin
            check("busy_in_ready", 64'(in_ready), 64'(0));
            tick();
            lat++;
        end
        check("busy5_latency", 64'(lat), 64'(P + 1));
        check("busy5_c", c, 64'h3333_3333_3333_3333);
        check("busy5_dz", 64'(dz), 64'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("busy_hs_out_valid", 64'(out_valid), 64'(0));
        check("busy_hs_in_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        check("busy9_accepted", 64'(in_ready), 64'(0));
        collect(32'd9, 0, "busy9");

        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) d = W'($urandom_range(1, 16));
            else d = $urandom;
            if (d == 0) d = 32'd1;
            issue(d);
            collect(d, $urandom_range(0, 2), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
